// File: rtl/uart_tx.sv
// UART transmitter: one start bit, DATA_BITS payload bits LSB first, one stop bit.
// Each bit is held for CLKS_PER_BIT clocks; TX, Busy and Done all come straight from flops.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] Data,
  input  logic                 Start,
  output logic                 TX,
  output logic                 Busy,
  output logic                 Done
);

  // state        | meaning
  // ST_IDLE      | line high, waiting for Start (Done strobes here after a frame)
  // ST_START_BIT | driving the low start bit
  // ST_DATA_BITS | shifting payload out LSB first
  // ST_STOP_BIT  | driving the high stop bit
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START_BIT,
    ST_DATA_BITS,
    ST_STOP_BIT
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      TX        <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          TX <= 1'b1;
          if (Start) begin
            shift_reg <= Data;
            cnt       <= '0;
            bit_idx   <= '0;
            TX        <= 1'b0;
            Busy      <= 1'b1;
            state     <= ST_START_BIT;
          end
        end
        ST_START_BIT: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            TX      <= shift_reg[0];
            state   <= ST_DATA_BITS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA_BITS: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              TX    <= 1'b1;
              state <= ST_STOP_BIT;
            end else begin
              // the bit now in shift_reg[1] is the next payload bit to go out
              bit_idx   <= bit_idx + 1'b1;
              TX        <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP_BIT: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            TX    <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          TX    <= 1'b1;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames plus random traffic, each cycle compared
// against the frame shape (start, LSB-first payload, stop, one Done cycle).
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int TOT = (DB + 2) * CPB;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic [DB-1:0] Data = '0;
  logic          Start = 1'b0;
  logic          TX, Busy, Done;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .Data  (Data),
    .Start (Start),
    .TX    (TX),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Line level for bit slot k of a frame carrying d.
  function automatic logic frame_bit(input logic [DB-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return d[k-1];
    return 1'b1;
  endfunction

  // Caller has Start=1/Data=d driven ahead of the accept edge.
  // Returns at the negedge of the Done cycle.
  task automatic frame(input logic [DB-1:0] d, input bit hold, input bit poke);
    for (int i = 0; i < TOT; i++) begin
      @(negedge CLK);
      check("tx", TX, frame_bit(d, i / CPB));
      check("busy", Busy, 1);
      check("done_low", Done, 0);
      if (i == 0 && !hold) begin
        Start = 1'b0;
        Data  = DB'($urandom);
      end
      if (poke && i == 10) begin
        Start = 1'b1;
        Data  = '1;
      end
      if (poke && i == 11 && !hold) Start = 1'b0;
    end
    @(negedge CLK);
    check("done_pulse", Done, 1);
    check("done_busy", Busy, 0);
    check("done_tx", TX, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      check("idle_tx", TX, 1);
      check("idle_busy", Busy, 0);
      check("idle_done", Done, 0);
    end
  endtask

  initial begin
    logic [DB-1:0] d;
    int gap;

    // reset state
    repeat (3) @(negedge CLK);
    check("rst_tx", TX, 1);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    Reset = 1'b0;
    idle(2);

    // 0xA5 reference frame
    Start = 1'b1; Data = 8'hA5;
    frame(8'hA5, 0, 0);
    idle(2);

    // all-zero then all-one payloads
    Start = 1'b1; Data = 8'h00;
    frame(8'h00, 0, 0);
    idle(1);
    Start = 1'b1; Data = 8'hFF;
    frame(8'hFF, 0, 0);
    idle(1);

    // Start held high: frames repeat with a single idle (Done) cycle between
    Start = 1'b1; Data = 8'h3C;
    repeat (3) frame(8'h3C, 1, 0);
    Start = 1'b0;
    idle(2);

    // Start re-pulsed mid-frame with new Data: ignored
    Start = 1'b1; Data = 8'h5A;
    frame(8'h5A, 0, 1);
    idle(3);

    // Reset during data bit 3
    Start = 1'b1; Data = 8'hC3;
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      check("pre_rst_tx", TX, frame_bit(8'hC3, i / CPB));
      if (i == 0) Start = 1'b0;
    end
    Reset = 1'b1;
    @(negedge CLK);
    check("abort_tx", TX, 1);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    Reset = 1'b0;
    idle(TOT + 2);
    Start = 1'b1; Data = 8'h96;
    frame(8'h96, 0, 0);
    idle(1);

    // Reset and Start on the same edge, then Start on the first free edge
    Reset = 1'b1; Start = 1'b1; Data = 8'h81;
    @(negedge CLK);
    check("rs_tx", TX, 1);
    check("rs_busy", Busy, 0);
    Reset = 1'b0; Data = 8'h81;
    frame(8'h81, 0, 0);
    idle(1);

    // random traffic: random payloads, gaps (0 = back-to-back), pokes
    for (int f = 0; f < 12; f++) begin
      d = DB'($urandom);
      gap = $urandom_range(0, 4);
      Start = 1'b1; Data = d;
      frame(d, 0, $urandom_range(0, 1) == 1);
      if (gap > 0) begin
        idle(gap);
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the CLK cycles per serial bit; legal values are 2 to 65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving the payload bits per frame; legal values are 5 to 9.
REQ-003 The block SHALL have port CLK  input  1  system clock, with all state updated on the rising edge.
REQ-004 The block SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port Data  input  DATA_BITS  parallel payload, sampled only on the accept edge.
REQ-006 The block SHALL have port Start  input  1  transmit request, level-sensitive.
REQ-007 The block SHALL have port TX  output  1  serial line, idle high, registered.
REQ-008 The block SHALL have port Busy  output  1  frame in progress, registered.
REQ-009 The block SHALL have port Done  output  1  one-cycle frame-complete strobe, registered.

Function
REQ-010 The block SHALL implement the states IDLE, START_BIT, DATA_BITS and STOP_BIT.
REQ-011 In IDLE, a rising edge with Start=1 SHALL accept the request: Data is latched into a shift register, the bit-period counter is cleared, and the state moves to START_BIT.
REQ-012 Start=0 in IDLE SHALL hold the state; Start in any other state SHALL be ignored, with no queuing.
REQ-013 In the cycle after acceptance, TX SHALL be 0 and Busy SHALL be 1.
REQ-014 Every bit SHALL drive TX for exactly CLKS_PER_BIT cycles, timed by a counter running 0 to CLKS_PER_BIT-1 that wraps to 0 at each bit boundary.
REQ-015 START_BIT SHALL drive TX=0 for one bit period.
REQ-016 DATA_BITS SHALL drive the DATA_BITS payload bits LSB first, with a bit index running 0 to DATA_BITS-1.
REQ-017 STOP_BIT SHALL drive TX=1 for one bit period, then return to IDLE.
REQ-018 Busy SHALL be 1 for exactly (DATA_BITS+2)*CLKS_PER_BIT consecutive cycles per frame.
REQ-019 Done SHALL be 1 for exactly one cycle, the first IDLE cycle after STOP_BIT, with Busy=0 and TX=1 in that cycle.
REQ-020 Start=1 during the Done cycle SHALL be accepted, giving back-to-back frames separated by exactly one idle cycle with TX=1.
REQ-021 Changes on Data after acceptance SHALL NOT affect the frame in flight.
REQ-022 TX SHALL come directly from a flop, with no combinational path from Start or Data to TX.
REQ-023 The counter width SHALL be sized from CLKS_PER_BIT so that no wrap occurs before CLKS_PER_BIT-1.

Reset
REQ-024 A rising edge with Reset=1 SHALL set TX=1, Busy=0 and Done=0, set the state to IDLE, and clear the counter, the bit index and the shift register.
REQ-025 Reset SHALL take priority over Start in the same cycle, so the request is not accepted.
REQ-026 Reset asserted mid-frame SHALL abort the frame, with TX=1 and Busy=0 in the following cycle and no Done pulse.
REQ-027 After Reset deasserts, the block SHALL accept a Start on the first rising edge with Reset=0.

Verification
REQ-028 With CLKS_PER_BIT=4, DATA_BITS=8, Data=8'hA5 and a one-cycle Start: TX SHALL carry 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles; Busy SHALL be high for 40 cycles; Done SHALL be high on cycle 41 only.
REQ-029 With Data=8'h00 and then 8'hFF: TX SHALL be low for 36 consecutive cycles, and then high for 36 cycles after the start bit (8 data bits plus the stop bit); Done SHALL pulse once per frame.
REQ-030 With Start held high continuously and Data=8'h3C: TX SHALL repeat the frame indefinitely, with exactly one TX=1 idle cycle (the Done cycle) between stop bit and start bit.
REQ-031 With Start pulsed at cycle 10 of a frame and Data changed to 8'hFF: the current frame SHALL be unchanged, no second frame SHALL start, and there SHALL be exactly one Done pulse.
REQ-032 With Reset pulsed during data bit 3: TX=1 and Busy=0 the next cycle, Done SHALL stay 0, and a new Start SHALL produce a clean full frame.
REQ-033 With Reset=1 and Start=1 on the same edge: no frame SHALL start, and TX SHALL stay 1.
